// File: rtl/bram_result_reader.sv
// Streams `count` words read from BRAM port B (starting at `base`) to a valid/ready consumer.
// Optional RDR_CHECKSUM_EN adds `chk`, the XOR of all beats accepted in the current transfer.
`ifndef RDR_N
`define RDR_N 16
`endif

module bram_result_reader #(
  parameter int a    = 32,
  parameter int W    = `RDR_N * 2,
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [a-1:0]      base,
  input  logic [`RDR_N-1:0] count,
  output logic              busy,
  output logic              done,
  output logic [a-1:0]      b_addr,
  input  logic [W-1:0]      b_dout,
  output logic [7:0]        b_we,
  output logic [W-1:0]      m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef RDR_CHECKSUM_EN
  , output logic [W-1:0]    chk
`endif
);

  localparam int N = `RDR_N;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state;
  logic [N-1:0]   count_q;
  logic [N-1:0]   issued;
  logic [N-1:0]   accepted;
  logic [a-1:0]   next_addr;
  // v1: b_addr holds an issued read this cycle; v2: b_dout carries its data this cycle.
  logic           v1;
  logic           v2;
  logic [2:0]     fifo_cnt;
  logic [1:0]     wr_ptr;
  logic [1:0]     rd_ptr;
  logic [W-1:0]   mem [4];

  logic           push;
  logic           pop;
  logic           can_issue;
  logic           drain_done;

  assign push       = v2;
  assign pop        = m_valid & m_ready;
  assign can_issue  = (state == RUN) && (issued != count_q) &&
                      ((fifo_cnt + 3'(v1) + 3'(v2)) < 3'd4);
  assign drain_done = (state == DRAIN) && !v1 && !v2 &&
                      ((fifo_cnt == 3'd0) || ((fifo_cnt == 3'd1) && pop));

  assign b_we    = 8'h00;
  assign m_valid = (fifo_cnt != 3'd0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign m_last  = m_valid && (accepted == count_q - N'(1));

  // NOTE: FIFO storage has no reset; m_data is gated by m_valid, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= b_dout;
  end

  // NOTE: all state here uses non-blocking assignments, so later assignments in this block override earlier ones cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      b_addr    <= '0;
      next_addr <= '0;
      count_q   <= '0;
      issued    <= '0;
      accepted  <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      fifo_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
`ifdef RDR_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      done <= 1'b0;
      v2   <= v1;
      v1   <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 2'd1;
        accepted <= accepted + N'(1);
`ifdef RDR_CHECKSUM_EN
        chk      <= chk ^ m_data;
`endif
      end

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            count_q  <= count;
            issued   <= '0;
            accepted <= '0;
`ifdef RDR_CHECKSUM_EN
            chk      <= '0;
`endif
            if (count == '0) begin
              state <= DRAIN;
            end else begin
              // The first read issues on the accepting edge itself.
              b_addr    <= base;
              next_addr <= base + a'(STEP);
              issued    <= N'(1);
              v1        <= 1'b1;
              state     <= (count == N'(1)) ? DRAIN : RUN;
            end
          end
        end

        RUN: begin
          if (can_issue) begin
            b_addr    <= next_addr;
            next_addr <= next_addr + a'(STEP);
            issued    <= issued + N'(1);
            v1        <= 1'b1;
            if (issued + N'(1) == count_q) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (drain_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bram_result_reader.md
# bram_result_reader

- Reads a block of network outputs (`y` vectors) back out of the `sbc` block-RAM and streams them to an external consumer over a valid/ready interface.
- It is the reader on the spare port B of the `y` memory, which the datapath fills on port A during inference.
- After a `start` pulse it issues `count` sequential reads from `base`.
- It absorbs the 1-cycle BRAM latency and consumer back-pressure with a 4-entry buffer, then pulses `done`.

## Interface
Parameters:
- `a`, 32, address width
- `W`, `` `n``*2, data word width (one `y` vector: `n`*sl)
- `STEP`, 4, address increment per word (byte addressing)

Ports:
- `clk` in 1: the single clock
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: begin transfer; sampled only in IDLE
- `base` in `a`: first word address; sampled with `start`
- `count` in `` `n``: words to read, unsigned; sampled with `start`
- `busy` out 1: high from the edge after accepted `start` until `done`
- `done` out 1: 1-cycle pulse after the last beat is accepted
- `b_addr` out `a`: BRAM port B address, registered
- `b_dout` in `W`: BRAM port B read data
- `b_we` out 8: held 8'h00
- `m_data` out `W`: stream data
- `m_valid` out 1: stream valid
- `m_ready` in 1: stream ready
- `m_last` out 1: high with the final beat

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE**
  - On `start`=1, latch `base`, `count` and go to RUN.
  - If `count`=0, go straight to DRAIN.
  - `start` in any other state is ignored.
- **RUN**
  - A read issues at an edge when `issued < count` and `fifo_cnt + pending < 4`.
  - Issuing loads `b_addr` with `base + issued*STEP`; address wraps modulo 2^`a`.
  - `pending` counts issued reads whose data is not yet captured; at most 2.
  - Data for the address held during cycle k is on `b_dout` in cycle k+1 and is written into the FIFO at the end of that cycle.
  - When `issued == count`, go to DRAIN.
- **DRAIN**
  - When `pending`=0, `fifo_cnt`=0 and all beats are accepted, pulse `done` and return to IDLE.
- **Stream**
  - `m_data` is the FIFO head; `m_valid` = (`fifo_cnt` != 0).
  - A beat transfers when `m_valid & m_ready`.
  - `m_data` and `m_valid` stay stable while `m_valid & !m_ready`.
  - `m_last` is high when the head is word `count-1`.
- **Simultaneous events:** FIFO write and read in the same cycle leave `fifo_cnt` unchanged. The FIFO never overflows because of the credit rule.
- **Width rules:** counters are `` `n`` bits; `base + issued*STEP` is computed in `a` bits, truncated.

## Timing
- Reset values: `busy`=0, `done`=0, `b_addr`=0, `b_we`=8'h00, `m_data`=0, `m_valid`=0, `m_last`=0. FSM goes to IDLE and all counters to 0.
- Reset asserted mid-transfer aborts immediately. No `done` pulse is produced, and buffered beats are discarded.
- With `start` accepted at edge 0:
  - `b_addr`=`base` in cycle 1;
  - data captured at edge 2;
  - `m_valid`=1 in cycle 3.
- With `m_ready` held high, throughput is 1 word/cycle. The last beat is in cycle `count`+2.
- `done` is high in the cycle after the edge that accepts the last beat.
- `count`=0: `done` is high in cycle 2, `busy` in cycle 1 only, no beats.
- `start` may be reasserted in the cycle `done` is high; it is accepted (FSM is IDLE).

## Configuration
- `RDR_CHECKSUM_EN` defined:
  - Adds output port `chk` [`W`-1:0]: the XOR of all beats accepted in the current transfer.
  - `chk` clears to 0 on an accepted `start` and on reset.
  - `chk` is valid while `done`=1 and holds until the next accepted `start`.
- Not defined: `chk` port and logic are absent; all other behaviour is identical.

## Test plan
- `base`=0x100, `count`=4, `m_ready`=1, BRAM preloaded with words 0xA..0xD:
  - `b_addr` 0x100, 0x104, 0x108, 0x10C in cycles 1-4;
  - beats 0xA..0xD in cycles 3-6, `m_last` in cycle 6;
  - `done` in cycle 7.
- `count`=6, `m_ready` low in cycles 3-10 and then high:
  - no more than 4 reads are issued before the first accept;
  - `m_data` stays 1st word throughout the stall;
  - all 6 words arrive in order, no loss or duplicates.
- `count`=0: no beats, `done` in cycle 2, `b_addr` unchanged.
- `base`=0xFFFFFFFC, `count`=2: `b_addr` 0xFFFFFFFC, then 0x00000000.
- Reset low during cycle 4 of an 8-word transfer: all outputs go to reset values at once, and a new transfer of 2 words afterwards completes normally.
- With `RDR_CHECKSUM_EN` defined, words 0x0F0, 0x00F, 0xF00: `chk`=0xFFF when `done`=1.
